// File: rtl/mac_tx_sched.sv
// Transmit scheduler: picks a queue (TTE strict priority or round-robin), reads the
// frame length from its pointer FIFO, then streams that many bytes to the GMII side.
module mac_tx_sched #(
    parameter int NUM_Q = 2,
    parameter int LEN_W = 12,
    parameter int IFG   = 12
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tx_enable,
    input  logic                tte_strict,
    input  logic [NUM_Q-1:0]    ptr_fifo_empty,
    output logic [NUM_Q-1:0]    ptr_fifo_rd,
    input  logic [NUM_Q*16-1:0] ptr_fifo_din,
    output logic [NUM_Q-1:0]    data_fifo_rd,
    input  logic [NUM_Q*8-1:0]  data_fifo_din,
    output logic                tx_en,
    output logic [7:0]          tx_d,
    output logic                tx_done,
    output logic [2:0]          tx_qid,
    output logic                len_err
);

    localparam int GAP_W = $clog2(IFG);

    typedef enum logic [2:0] {IDLE, PTR, PLEN, DATA, GAP} state_t;

    state_t           state, state_nx;
    logic [2:0]       sel, sel_nx, rr_ptr, rr_nx, pick;
    logic             found;
    logic [LEN_W-1:0] cnt, cnt_nx, plen;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic [NUM_Q-1:0] ptr_rd_nx, data_rd_nx, sel_oh, pick_oh;
    logic             tx_en_nx, tx_done_nx, len_err_nx;
    logic [7:0]       cur_byte;
    logic             unused_ptr_bits;

    // Only the length field of each pointer word matters here.
    assign unused_ptr_bits = ^ptr_fifo_din;

    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        if (tte_strict && !ptr_fifo_empty[0]) begin
            found = 1'b1;
        end else begin
            for (int i = 0; i < NUM_Q; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_Q) idx = idx - NUM_Q;
                if (!found && !ptr_fifo_empty[idx]) begin
                    pick  = 3'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        plen     = '0;
        cur_byte = '0;
        sel_oh   = '0;
        pick_oh  = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (sel == 3'(q)) begin
                plen      = ptr_fifo_din[16*q +: LEN_W];
                cur_byte  = data_fifo_din[8*q +: 8];
                sel_oh[q] = 1'b1;
            end
            if (pick == 3'(q)) pick_oh[q] = 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        sel_nx     = sel;
        rr_nx      = rr_ptr;
        cnt_nx     = cnt;
        gap_nx     = gap_cnt;
        ptr_rd_nx  = '0;
        data_rd_nx = '0;
        tx_en_nx   = |data_fifo_rd;
        tx_done_nx = 1'b0;
        len_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (tx_enable && found) begin
                    sel_nx    = pick;
                    rr_nx     = (int'(pick) == NUM_Q - 1) ? 3'd0 : pick + 3'd1;
                    ptr_rd_nx = pick_oh;
                    state_nx  = PTR;
                end
            end
            PTR: state_nx = PLEN;
            PLEN: begin
                if (plen == '0) begin
                    len_err_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx     = plen;
                    data_rd_nx = sel_oh;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                // The strobe is registered, so the last read is issued while cnt is 1.
                if (cnt == LEN_W'(1)) begin
                    cnt_nx     = '0;
                    tx_done_nx = 1'b1;
                    gap_nx     = GAP_W'(IFG - 4);
                    state_nx   = GAP;
                end else begin
                    cnt_nx     = cnt - LEN_W'(1);
                    data_rd_nx = sel_oh;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nx = IDLE;
                else               gap_nx   = gap_cnt - GAP_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            sel          <= '0;
            rr_ptr       <= '0;
            cnt          <= '0;
            gap_cnt      <= '0;
            ptr_fifo_rd  <= '0;
            data_fifo_rd <= '0;
            tx_en        <= 1'b0;
            tx_done      <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state        <= state_nx;
            sel          <= sel_nx;
            rr_ptr       <= rr_nx;
            cnt          <= cnt_nx;
            gap_cnt      <= gap_nx;
            ptr_fifo_rd  <= ptr_rd_nx;
            data_fifo_rd <= data_rd_nx;
            tx_en        <= tx_en_nx;
            tx_done      <= tx_done_nx;
            len_err      <= len_err_nx;
        end
    end

    // The data FIFO output is already a register; it is muxed straight onto tx_d.
    assign tx_d   = tx_en ? cur_byte : 8'h00;
    assign tx_qid = sel;

endmodule

// File: tb/tb_mac_tx_sched.sv
// Directed bench for mac_tx_sched: behavioural pointer/data FIFOs, a frame monitor,
// a table of single-frame vectors and hand-written multi-frame sequences.
module tb_mac_tx_sched;

    localparam int NUM_Q = 2;
    localparam int LEN_W = 12;
    localparam int IFG   = 12;
    localparam int MAXF  = 64;

    logic                clk = 1'b0;
    logic                rstn, tx_enable, tte_strict;
    logic [NUM_Q-1:0]    ptr_fifo_empty, ptr_fifo_rd, data_fifo_rd;
    logic [NUM_Q*16-1:0] ptr_fifo_din;
    logic [NUM_Q*8-1:0]  data_fifo_din;
    logic                tx_en, tx_done, len_err;
    logic [7:0]          tx_d;
    logic [2:0]          tx_qid;

    always #5 clk = ~clk;

    mac_tx_sched #(.NUM_Q(NUM_Q), .LEN_W(LEN_W), .IFG(IFG)) dut (
        .clk(clk), .rstn(rstn), .tx_enable(tx_enable), .tte_strict(tte_strict),
        .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_din(ptr_fifo_din),
        .data_fifo_rd(data_fifo_rd), .data_fifo_din(data_fifo_din),
        .tx_en(tx_en), .tx_d(tx_d), .tx_done(tx_done), .tx_qid(tx_qid), .len_err(len_err)
    );

    // Behavioural FIFOs with one-cycle read latency.
    logic [15:0] ptr_mem  [NUM_Q][64];
    logic [7:0]  data_mem [NUM_Q][8192];
    int          ptr_wr [NUM_Q];
    int          ptr_rdi [NUM_Q];
    int          data_wr [NUM_Q];
    int          data_rdi [NUM_Q];
    logic        flush_req = 1'b0;

    always_comb begin
        for (int q = 0; q < NUM_Q; q++) ptr_fifo_empty[q] = (ptr_rdi[q] == ptr_wr[q]);
    end

    always @(posedge clk) begin
        for (int q = 0; q < NUM_Q; q++) begin
            if (flush_req) begin
                ptr_rdi[q]  <= ptr_wr[q];
                data_rdi[q] <= data_wr[q];
            end else begin
                if (ptr_fifo_rd[q] && ptr_rdi[q] != ptr_wr[q]) begin
                    ptr_fifo_din[16*q +: 16] <= ptr_mem[q][ptr_rdi[q]];
                    ptr_rdi[q] <= ptr_rdi[q] + 1;
                end
                if (data_fifo_rd[q] && data_rdi[q] != data_wr[q]) begin
                    data_fifo_din[8*q +: 8] <= data_mem[q][data_rdi[q]];
                    data_rdi[q] <= data_rdi[q] + 1;
                end
            end
        end
    end

    // Frame monitor
    int   cyc = 0;
    int   n_frames = 0, n_ptr = 0, n_dread = 0, n_lenerr = 0, n_viol = 0, n_stray = 0;
    int   cur_len = 0, low_cnt = 0;
    bit   in_frame = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    int   f_len [MAXF], f_first [MAXF], f_qid [MAXF], f_gap [MAXF];
    int   f_bad [MAXF], f_trunc [MAXF], f_start [MAXF], ptr_cyc [MAXF];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ($countones(ptr_fifo_rd) > 1 || $countones(data_fifo_rd) > 1) n_viol++;
        if (|ptr_fifo_rd) begin
            if (n_ptr < MAXF) ptr_cyc[n_ptr] = cyc;
            n_ptr++;
        end
        if (|data_fifo_rd) n_dread++;
        if (len_err) n_lenerr++;
        if (tx_en === 1'b1) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                cur_len  = 0;
                f_start[n_frames] = cyc;
                f_gap[n_frames]   = low_cnt;
                f_qid[n_frames]   = int'(tx_qid);
                f_first[n_frames] = int'(tx_d);
                f_bad[n_frames]   = 0;
                f_trunc[n_frames] = 0;
            end else if (tx_d != 8'(prev_byte + 8'd1)) begin
                f_bad[n_frames] = 1;
            end
            if (int'(tx_qid) != f_qid[n_frames]) f_bad[n_frames] = 1;
            prev_byte = tx_d;
            cur_len++;
            if (tx_done) begin
                f_len[n_frames] = cur_len;
                in_frame = 1'b0;
                low_cnt  = 0;
                n_frames++;
            end
        end else begin
            if (in_frame) begin
                f_len[n_frames]   = cur_len;
                f_trunc[n_frames] = 1;
                in_frame = 1'b0;
                low_cnt  = 0;
                n_frames++;
            end
            if (tx_done === 1'b1) n_stray++;
            low_cnt++;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic load_frame(input int q, input int len, input int first);
        for (int i = 0; i < len; i++) data_mem[q][data_wr[q] + i] = 8'(first + i);
        data_wr[q] = data_wr[q] + len;
        ptr_mem[q][ptr_wr[q]] = 16'hA000 | 16'(len);
        ptr_wr[q] = ptr_wr[q] + 1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int waited = 0;
        while (n_frames < target && waited < budget) begin
            tick();
            waited++;
        end
        checks++;
        if (n_frames < target) begin
            failures++;
            $display("[TB] FAIL %s: frames seen %0d expected %0d", name, n_frames, target);
        end
    endtask

    task automatic wait_bytes(input int n, input string name);
        int waited = 0;
        while (!(in_frame && cur_len == n) && waited < 300) begin
            tick();
            waited++;
        end
        checks++;
        if (!(in_frame && cur_len == n)) begin
            failures++;
            $display("[TB] FAIL %s: byte count %0d expected %0d", name, cur_len, n);
        end
    endtask

    typedef struct {
        int   q;
        int   len;
        int   first;
        logic strict;
        int   exp_q;
    } vec_t;

    vec_t vecs [5];

    task automatic applyStimulus(input vec_t v);
        int k;
        k = n_frames;
        tte_strict = v.strict;
        load_frame(v.q, v.len, v.first);
        wait_frames(k + 1, v.len + 40, "vec_wait");
        checkOutput("vec_qid",   32'(f_qid[k]),   32'(v.exp_q));
        checkOutput("vec_len",   32'(f_len[k]),   32'(v.len));
        checkOutput("vec_first", 32'(f_first[k]), 32'(v.first));
        checkOutput("vec_bytes", 32'(f_bad[k]),   32'd0);
    endtask

    initial begin
        int k, p0, ld, d0, e0, eq, ef;

        vecs[0] = '{q: 0, len: 1,   first: 8'hA5, strict: 1'b1, exp_q: 0};
        vecs[1] = '{q: 1, len: 2,   first: 8'hFE, strict: 1'b0, exp_q: 1};
        vecs[2] = '{q: 0, len: 17,  first: 8'h33, strict: 1'b0, exp_q: 0};
        vecs[3] = '{q: 1, len: 255, first: 8'h80, strict: 1'b1, exp_q: 1};
        vecs[4] = '{q: 1, len: 3,   first: 8'h00, strict: 1'b1, exp_q: 1};

        rstn = 1'b0;
        tx_enable = 1'b0;
        tte_strict = 1'b0;
        repeat (3) tick();
        checkOutput("rst_tx_en",    32'(tx_en),        32'd0);
        checkOutput("rst_tx_d",     32'(tx_d),         32'd0);
        checkOutput("rst_tx_done",  32'(tx_done),      32'd0);
        checkOutput("rst_len_err",  32'(len_err),      32'd0);
        checkOutput("rst_tx_qid",   32'(tx_qid),       32'd0);
        checkOutput("rst_ptr_rd",   32'(ptr_fifo_rd),  32'd0);
        checkOutput("rst_data_rd",  32'(data_fifo_rd), 32'd0);
        rstn = 1'b1;
        tx_enable = 1'b1;
        repeat (2) tick();

        // Single 64-byte frame on queue 1: latency and content.
        ld = cyc;
        p0 = n_ptr;
        k  = n_frames;
        load_frame(1, 64, 8'h00);
        wait_frames(k + 1, 200, "lat_wait");
        checkOutput("lat_ptr_rd", 32'(ptr_cyc[p0] - ld), 32'd1);
        checkOutput("lat_tx_en",  32'(f_start[k] - ld),  32'd4);
        checkOutput("lat_len",    32'(f_len[k]),         32'd64);
        checkOutput("lat_first",  32'(f_first[k]),       32'd0);
        checkOutput("lat_bytes",  32'(f_bad[k]),         32'd0);
        checkOutput("lat_qid",    32'(f_qid[k]),         32'd1);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // Strict priority: all queue-0 frames first.
        tx_enable = 1'b0;
        tte_strict = 1'b1;
        repeat (15) tick();
        for (int i = 0; i < 3; i++) load_frame(0, 4, 16 * (i + 1));
        for (int i = 0; i < 3; i++) load_frame(1, 4, 16 * (i + 4));
        k = n_frames;
        tx_enable = 1'b1;
        wait_frames(k + 6, 400, "strict_wait");
        for (int j = 0; j < 6; j++) begin
            checkOutput("strict_qid",   32'(f_qid[k + j]),   (j < 3) ? 32'd0 : 32'd1);
            checkOutput("strict_first", 32'(f_first[k + j]), 32'(16 * (j + 1)));
        end
        tte_strict = 1'b0;

        // Back-to-back frames on one queue.
        k = n_frames;
        load_frame(1, 60, 8'h10);
        load_frame(1, 60, 8'h60);
        wait_frames(k + 2, 300, "b2b_wait");
        checkOutput("b2b_gap",  32'(f_gap[k + 1]), 32'(IFG));
        checkOutput("b2b_len0", 32'(f_len[k]),     32'd60);
        checkOutput("b2b_len1", 32'(f_len[k + 1]), 32'd60);

        // Zero-length pointer dropped, next frame unaffected.
        d0 = n_dread;
        e0 = n_lenerr;
        k  = n_frames;
        load_frame(0, 0, 0);
        load_frame(0, 10, 8'hC0);
        wait_frames(k + 1, 100, "len0_wait");
        checkOutput("len0_err",   32'(n_lenerr - e0), 32'd1);
        checkOutput("len0_reads", 32'(n_dread - d0),  32'd10);
        checkOutput("len0_len",   32'(f_len[k]),      32'd10);
        checkOutput("len0_first", 32'(f_first[k]),    32'hC0);

        // tx_enable dropped mid-frame.
        p0 = n_ptr;
        k  = n_frames;
        load_frame(0, 40, 8'h20);
        load_frame(0, 5, 8'h90);
        wait_bytes(5, "en_byte5");
        tx_enable = 1'b0;
        wait_frames(k + 1, 200, "en_wait");
        checkOutput("en_len",   32'(f_len[k]),   32'd40);
        checkOutput("en_trunc", 32'(f_trunc[k]), 32'd0);
        checkOutput("en_bytes", 32'(f_bad[k]),   32'd0);
        repeat (30) tick();
        checkOutput("en_no_ptr",    32'(n_ptr - p0), 32'd1);
        checkOutput("en_no_frame",  32'(n_frames),   32'(k + 1));
        tx_enable = 1'b1;
        wait_frames(k + 2, 100, "en_resume");
        checkOutput("en_resume_len",   32'(f_len[k + 1]),   32'd5);
        checkOutput("en_resume_first", 32'(f_first[k + 1]), 32'h90);

        // Longest representable frame.
        k = n_frames;
        load_frame(0, 4095, 8'h00);
        wait_frames(k + 1, 4300, "max_wait");
        checkOutput("max_len",   32'(f_len[k]),   32'd4095);
        checkOutput("max_bytes", 32'(f_bad[k]),   32'd0);
        checkOutput("max_trunc", 32'(f_trunc[k]), 32'd0);

        // Reset at byte 20 of a 100-byte frame on queue 0.
        k = n_frames;
        load_frame(0, 100, 8'h00);
        wait_bytes(20, "rst_byte20");
        rstn = 1'b0;
        tick();
        checkOutput("midrst_tx_en",   32'(tx_en),        32'd0);
        checkOutput("midrst_ptr_rd",  32'(ptr_fifo_rd),  32'd0);
        checkOutput("midrst_data_rd", 32'(data_fifo_rd), 32'd0);
        checkOutput("midrst_qid",     32'(tx_qid),       32'd0);
        checkOutput("midrst_trunc",   32'(f_trunc[k]),   32'd1);
        checkOutput("midrst_len",     32'(f_len[k]),     32'd20);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        rstn = 1'b1;
        tick();

        // Round-robin from a freshly reset pointer: 0,1,0,1,0,1.
        tx_enable = 1'b0;
        for (int i = 0; i < 3; i++) load_frame(0, 3, 16 * (i + 1));
        for (int i = 0; i < 3; i++) load_frame(1, 3, 16 * (i + 4));
        k = n_frames;
        tx_enable = 1'b1;
        wait_frames(k + 6, 400, "rr_wait");
        for (int j = 0; j < 6; j++) begin
            eq = j % 2;
            ef = (eq == 0) ? 16 * (j / 2 + 1) : 16 * (j / 2 + 4);
            checkOutput("rr_qid",   32'(f_qid[k + j]),   32'(eq));
            checkOutput("rr_first", 32'(f_first[k + j]), 32'(ef));
        end

        checkOutput("onehot_strobes", 32'(n_viol),  32'd0);
        checkOutput("stray_done",     32'(n_stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_tx_sched.md
MAC_TX_SCHED -- requirements
Module: mac_tx_sched

Interface
REQ-001 SHALL have parameter NUM_Q, default 2, meaning number of transmit queues; queue 0 is the TTE queue; legal range 2..8.
REQ-002 SHALL have parameter LEN_W, default 12, meaning the width of the frame-length field in the pointer word.
REQ-003 SHALL have parameter IFG, default 12, meaning the minimum number of tx_en-low cycles between back-to-back frames; legal value IFG >= 4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port tx_enable, input, 1 bit: when 0, no new frame starts.
REQ-007 SHALL have port tte_strict, input, 1 bit: 1 = queue 0 has strict priority; 0 = all queues round-robin.
REQ-008 SHALL have port ptr_fifo_empty, input, NUM_Q bits: per-queue pointer FIFO empty flag.
REQ-009 SHALL have port ptr_fifo_rd, output, NUM_Q bits: per-queue pointer FIFO read strobe.
REQ-010 SHALL have port ptr_fifo_din, input, NUM_Q*16 bits: packed pointer words; queue q occupies [16q+15:16q]; length is in [LEN_W-1:0].
REQ-011 SHALL have port data_fifo_rd, output, NUM_Q bits: per-queue data FIFO read strobe.
REQ-012 SHALL have port data_fifo_din, input, NUM_Q*8 bits: packed data bytes; queue q occupies [8q+7:8q].
REQ-013 SHALL have port tx_en, output, 1 bit: byte-valid to the GMII transmitter.
REQ-014 SHALL have port tx_d, output, 8 bits: the transmit byte.
REQ-015 SHALL have port tx_done, output, 1 bit: one-cycle pulse when the last byte of a frame is driven.
REQ-016 SHALL have port tx_qid, output, 3 bits: queue of the current or last frame.
REQ-017 SHALL have port len_err, output, 1 bit: one-cycle pulse when a zero-length pointer is dropped.

Function
REQ-018 Both FIFO types SHALL be read with one-cycle latency: din is valid in the cycle after rd is high.
REQ-019 SHALL implement an FSM with states IDLE, PTR, PLEN, DATA and GAP; all outputs SHALL be registered.
REQ-020 IDLE: when tx_enable=1 and any ptr_fifo_empty bit is 0, SHALL select a queue, latch it into tx_qid, and go to PTR.
REQ-021 Selection with tte_strict=1 and queue 0 non-empty SHALL pick queue 0.
REQ-022 In all other cases selection SHALL pick the first non-empty queue at or after rr_ptr (modulo NUM_Q); rr_ptr resets to 0 and becomes selected+1 mod NUM_Q after each selection, including a queue-0 strict selection.
REQ-023 PTR SHALL assert ptr_fifo_rd[sel] for exactly one cycle and then go to PLEN.
REQ-024 PLEN SHALL capture len = ptr_fifo_din[sel][LEN_W-1:0].
REQ-025 In PLEN, if len=0 the block SHALL pulse len_err, read no data, and return to IDLE; otherwise it SHALL go to DATA.
REQ-026 DATA SHALL assert data_fifo_rd[sel] on exactly len consecutive cycles and then go to GAP.
REQ-027 tx_en SHALL be high, with tx_d = data_fifo_din[sel], on the len cycles that each follow a data read, with no bubbles.
REQ-028 tx_done SHALL pulse coincident with the last tx_en-high cycle.
REQ-029 GAP SHALL last IFG-3 cycles (the first of them carries the last byte); back-to-back frames therefore show exactly IFG tx_en-low cycles.
REQ-030 Deasserting tx_enable mid-frame SHALL NOT truncate the frame; it only blocks the IDLE-to-PTR transition.
REQ-031 Changes to ptr_fifo_empty or tte_strict after the selection SHALL NOT affect the frame in progress.
REQ-032 A frame of len = 2^LEN_W - 1 SHALL be transmitted in full; the byte counter SHALL be LEN_W bits and SHALL NOT wrap early.
REQ-033 At most one bit of ptr_fifo_rd or data_fifo_rd SHALL be high in any cycle, and never in an IDLE cycle.

Reset
REQ-034 While rstn=0 at a clock edge, the next state SHALL be IDLE, with rr_ptr=0, all rd strobes=0, tx_en=0, tx_d=0, tx_done=0, len_err=0, tx_qid=0 and the counters at 0.
REQ-035 Reset asserted mid-frame SHALL drive tx_en to 0 on the following cycle and abandon the frame; flushing the FIFOs is not this block's job.

Verification
REQ-036 Queue 1 holds ptr len=64 with bytes 0x00..0x3F -> ptr_rd[1] in cycle t+1 of IDLE detection, first tx_en in cycle t+4, 64 contiguous bytes 0x00..0x3F, tx_done on byte 64, tx_qid=1.
REQ-037 Queues 0 and 1 hold 3 frames each, tte_strict=1 -> all queue-0 frames go first; with tte_strict=0 the order is 0,1,0,1,0,1.
REQ-038 Back-to-back frames of len 60 on one queue, IFG=12 -> exactly 12 tx_en-low cycles between frames.
REQ-039 Pointer with len=0, then len=10 -> a len_err pulse, no data_fifo_rd for the first, the second frame transmitted normally.
REQ-040 rstn=0 at byte 20 of a 100-byte frame -> tx_en=0 on the next cycle, all strobes low, FSM in IDLE, rr_ptr=0.
REQ-041 tx_enable dropped at byte 5 of 40 -> all 40 bytes sent; no PTR entry until tx_enable returns to 1.
